// File: rtl/eda_img_pkg.sv
// Shared definitions for the image-scan blocks: sweep FSM states, neighbour
// mask bit positions and the mapping from mask bit to 3x3 window slot.
package eda_img_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  localparam int UPLEFT    = 7;
  localparam int UP        = 6;
  localparam int UPRIGHT   = 5;
  localparam int LEFT      = 4;
  localparam int RIGHT     = 3;
  localparam int DOWNLEFT  = 2;
  localparam int DOWN      = 1;
  localparam int DOWNRIGHT = 0;

  localparam int NUM_NEIGH   = 8;
  localparam int CENTER_SLOT = 4;

  // Window slots run 0 (upleft) .. 8 (downright); slot 0 sits in the window MSBs.
  function automatic int nb_slot(input int b);
    case (b)
      UPLEFT:   return 0;
      UP:       return 1;
      UPRIGHT:  return 2;
      LEFT:     return 3;
      RIGHT:    return 5;
      DOWNLEFT: return 6;
      DOWN:     return 7;
      default:  return 8;
    endcase
  endfunction

endpackage

// File: rtl/eda_win_cmp.sv
// Combinational 3x3 local-maximum test: center against every neighbour whose
// mask bit is set, unsigned. An empty mask yields ge = gt = 1.
module eda_win_cmp
  import eda_img_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9
) (
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window,
  input  logic [NUM_NEIGH-1:0]                mask,
  output logic                                ge,
  output logic                                gt
);

  logic [PIXEL_WIDTH-1:0] center;
  logic [NUM_NEIGH-1:0]   nb_ge;
  logic [NUM_NEIGH-1:0]   nb_gt;

  assign center = window[(WINDOW_WIDTH-1-CENTER_SLOT)*PIXEL_WIDTH +: PIXEL_WIDTH];

  for (genvar k = 0; k < NUM_NEIGH; k++) begin : g_nb
    localparam int SLOT = nb_slot(k);
    logic [PIXEL_WIDTH-1:0] nb;
    assign nb       = window[(WINDOW_WIDTH-1-SLOT)*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign nb_ge[k] = ~mask[k] | (center >= nb);
    assign nb_gt[k] = ~mask[k] | (center > nb);
  end

  assign ge = &nb_ge;
  assign gt = &nb_gt;

endmodule

// File: rtl/eda_max_scan.sv
// Raster sweep over an MxN image: issues one window address per cycle, flags
// local maxima one cycle later behind a valid/ready handshake, counts candidates.
module eda_max_scan
  import eda_img_pkg::*;
#(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9,
  parameter int I_WIDTH      = $clog2(M),
  parameter int J_WIDTH      = $clog2(N),
  parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  output logic [ADDR_WIDTH-1:0]               center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [7:0]                          neigh_addr_valid,
  output logic                                flag_valid,
  input  logic                                flag_ready,
  output logic [ADDR_WIDTH-1:0]               flag_addr,
  output logic                                flag_ge,
  output logic                                flag_gt,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH:0]                 cand_count
);

  scan_state_e           state_q, state_d;
  logic [I_WIDTH-1:0]    i_q, i_d;
  logic [J_WIDTH-1:0]    j_q, j_d;
  logic                  fv_q, fv_d;
  logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
  logic                  fge_q, fge_d;
  logic                  fgt_q, fgt_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  logic win_ge, win_gt;
  logic xfer, accept, last_addr;

  eda_win_cmp #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .WINDOW_WIDTH (WINDOW_WIDTH)
  ) u_cmp (
    .window (window_values),
    .mask   (neigh_addr_valid),
    .ge     (win_ge),
    .gt     (win_gt)
  );

  assign xfer      = fv_q && flag_ready;
  // The result slot frees up in the same cycle it drains, so the sweep never bubbles.
  assign accept    = (state_q == SCAN) && (!fv_q || flag_ready);
  assign last_addr = (i_q == I_WIDTH'(M-1)) && (j_q == J_WIDTH'(N-1));

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    fv_d    = fv_q;
    faddr_d = faddr_q;
    fge_d   = fge_q;
    fgt_d   = fgt_q;
    cnt_d   = cnt_q;

    if (xfer) begin
      fv_d = 1'b0;
      if (fge_q) cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          i_d     = '0;
          j_d     = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (accept) begin
          fv_d    = 1'b1;
          faddr_d = {i_q, j_q};
          fge_d   = win_ge;
          fgt_d   = win_gt;
          if (last_addr) begin
            state_d = DRAIN;
            i_d     = '0;
            j_d     = '0;
          end else if (j_q == J_WIDTH'(N-1)) begin
            j_d = '0;
            i_d = i_q + I_WIDTH'(1);
          end else begin
            j_d = j_q + J_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (xfer) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      fv_q    <= 1'b0;
      faddr_q <= '0;
      fge_q   <= 1'b0;
      fgt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      fv_q    <= fv_d;
      faddr_q <= faddr_d;
      fge_q   <= fge_d;
      fgt_q   <= fgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign center_addr = {i_q, j_q};
  assign flag_valid  = fv_q;
  assign flag_addr   = faddr_q;
  assign flag_ge     = fge_q;
  assign flag_gt     = fgt_q;
  assign busy        = (state_q == SCAN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign cand_count  = cnt_q;

endmodule

// File: tb/tb_eda_max_scan.sv
// Directed bench for eda_max_scan: a behavioural image RAM feeds windows, a
// negedge monitor records transfers, checks use hand-derived expectations.
module tb_eda_max_scan;

  localparam int M = 16;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  center_addr;
  logic [71:0] window_values;
  logic [7:0]  neigh_addr_valid;
  logic        flag_valid;
  logic        flag_ready;
  logic [7:0]  flag_addr;
  logic        flag_ge;
  logic        flag_gt;
  logic        busy;
  logic        done;
  logic [8:0]  cand_count;

  eda_max_scan dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .center_addr      (center_addr),
    .window_values    (window_values),
    .neigh_addr_valid (neigh_addr_valid),
    .flag_valid       (flag_valid),
    .flag_ready       (flag_ready),
    .flag_addr        (flag_addr),
    .flag_ge          (flag_ge),
    .flag_gt          (flag_gt),
    .busy             (busy),
    .done             (done),
    .cand_count       (cand_count)
  );

  always #5 clk = ~clk;

  logic [7:0] img [0:M-1][0:N-1];

  function automatic bit in_img(input int r, input int c);
    return (r >= 0) && (r < M) && (c >= 0) && (c < N);
  endfunction

  // Image RAM: out-of-image neighbours read the wrapped pixel, the mask marks them invalid.
  always_comb begin
    window_values    = '0;
    neigh_addr_valid = '0;
    for (int s = 0; s < 9; s++) begin
      window_values[(8-s)*8 +: 8] =
        img[(int'(center_addr[7:4]) + s/3 - 1 + M) % M][(int'(center_addr[3:0]) + s%3 - 1 + N) % N];
      if (s != 4 && in_img(int'(center_addr[7:4]) + s/3 - 1, int'(center_addr[3:0]) + s%3 - 1))
        neigh_addr_valid[(s < 4) ? 7-s : 8-s] = 1'b1;
    end
  end

  function automatic void ref_flags(input int a, output logic ge, output logic gt);
    int ci, cj;
    ci = a / N;
    cj = a % N;
    ge = 1'b1;
    gt = 1'b1;
    for (int di = -1; di <= 1; di++)
      for (int dj = -1; dj <= 1; dj++)
        if ((di != 0 || dj != 0) && in_img(ci+di, cj+dj)) begin
          if (img[ci][cj] <  img[ci+di][cj+dj]) ge = 1'b0;
          if (img[ci][cj] <= img[ci+di][cj+dj]) gt = 1'b0;
        end
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  int cyc = 0;
  int rec_n, order_err, flag_err, n_ge, n_gt, done_n;
  int first_cyc, last_cyc, done_cyc;
  bit rge [0:M*N-1];
  bit rgt [0:M*N-1];

  always @(negedge clk) begin
    logic ege, egt;
    cyc++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (flag_valid && flag_ready) begin
      if (flag_addr != rec_n[7:0]) order_err++;
      ref_flags(int'(flag_addr), ege, egt);
      if (flag_ge !== ege || flag_gt !== egt) flag_err++;
      rge[flag_addr] = flag_ge;
      rgt[flag_addr] = flag_gt;
      if (flag_ge) n_ge++;
      if (flag_gt) n_gt++;
      if (rec_n == 0) first_cyc = cyc;
      last_cyc = cyc;
      rec_n++;
    end
  end

  // Runs one sweep; negative arguments disable the stall, reset or stray-start event.
  task automatic sweep(input int stall_at, input int rst_at, input int start_at);
    bit stalled, pulsed, timed_out;
    logic [7:0] s_addr, s_ctr;
    logic       s_v, s_ge, s_gt;
    int         unstable;
    rec_n = 0; order_err = 0; flag_err = 0; n_ge = 0; n_gt = 0; done_n = 0;
    first_cyc = 0; last_cyc = 0; done_cyc = 0;
    stalled = 0; pulsed = 0; timed_out = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done_n > 0) begin
        timed_out = 0;
        break;
      end
      if (stall_at >= 0 && rec_n == stall_at && !stalled) begin
        stalled = 1;
        flag_ready = 1'b0;
        @(negedge clk);
        s_v = flag_valid; s_addr = flag_addr; s_ge = flag_ge; s_gt = flag_gt; s_ctr = center_addr;
        unstable = 0;
        repeat (4) begin
          @(negedge clk);
          if ({flag_valid, flag_addr, flag_ge, flag_gt, center_addr} !== {s_v, s_addr, s_ge, s_gt, s_ctr})
            unstable++;
        end
        @(posedge clk); #1;
        flag_ready = 1'b1;
        chk("stall_valid", 32'(s_v), 1);
        chk("stall_addr_is_20", 32'(s_addr), 20);
        chk("stall_stable", unstable, 0);
      end
      if (rst_at >= 0 && rec_n == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs",
            32'({busy, done, flag_valid, flag_ge, flag_gt, center_addr, flag_addr, cand_count}), 0);
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("midrst_no_done", done_n, 0);
        chk("midrst_idle", 32'({busy, flag_valid}), 0);
        timed_out = 0;
        break;
      end
      if (start_at >= 0 && rec_n >= start_at && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("sweep_timeout", 32'(timed_out), 0);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        img[i][j] = v;
  endtask

  initial begin
    int base_cnt, nb_sum;
    reset_n    = 1'b0;
    start      = 1'b0;
    flag_ready = 1'b1;
    fill(8'h40);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'({busy, done, flag_valid, flag_ge, flag_gt}), 0);
    chk("reset_center_addr", 32'(center_addr), 0);
    chk("reset_flag_addr", 32'(flag_addr), 0);
    chk("reset_cand_count", 32'(cand_count), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Uniform image: every pixel ties with its neighbours.
    sweep(-1, -1, -1);
    chk("uni_results", rec_n, 256);
    chk("uni_order", order_err, 0);
    chk("uni_n_ge", n_ge, 256);
    chk("uni_n_gt", n_gt, 0);
    chk("uni_cand_count", 32'(cand_count), 256);
    chk("uni_done_pulses", done_n, 1);
    chk("uni_done_latency", done_cyc - last_cyc, 1);
    chk("uni_back_to_back", last_cyc - first_cyc, 255);
    chk("uni_idle_after", 32'({busy, done}), 0);

    // Single peak at {5,7}.
    fill(8'h00);
    img[5][7] = 8'hFF;
    sweep(-1, -1, -1);
    nb_sum = 0;
    for (int di = -1; di <= 1; di++)
      for (int dj = -1; dj <= 1; dj++)
        if (di != 0 || dj != 0) nb_sum += int'(rge[(5+di)*N + 7 + dj]);
    chk("peak_gt", 32'(rgt[5*N+7]), 1);
    chk("peak_n_gt", n_gt, 1);
    chk("peak_neigh_ge", nb_sum, 0);
    chk("peak_cand_count", 32'(cand_count), 248);
    chk("peak_flags_model", flag_err, 0);

    // Corner {0,0}: wrapped locations hold bigger values but are masked out.
    fill(8'h00);
    img[0][0] = 8'h10;
    img[0][1] = 8'h0F; img[1][0] = 8'h0F; img[1][1] = 8'h0F;
    img[M-1][N-1] = 8'hFF; img[M-1][0] = 8'hFF; img[M-1][1] = 8'hFF;
    img[0][N-1] = 8'hFF; img[1][N-1] = 8'hFF;
    sweep(-1, -1, -1);
    chk("corner_gt", 32'(rgt[0]), 1);
    chk("corner_ge", 32'(rge[0]), 1);
    chk("corner_right_ge", 32'(rge[1]), 0);
    chk("corner_flags_model", flag_err, 0);

    // Textured image: no-stall baseline, then the same sweep with a 5-cycle stall.
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        img[i][j] = 8'((i*37 + j*11 + i*j*5) % 61);
    sweep(-1, -1, -1);
    base_cnt = int'(cand_count);
    chk("base_flags_model", flag_err, 0);
    chk("base_cand_vs_ge", base_cnt, n_ge);
    sweep(20, -1, -1);
    chk("stall_results", rec_n, 256);
    chk("stall_order", order_err, 0);
    chk("stall_flags_model", flag_err, 0);
    chk("stall_cand_count", 32'(cand_count), 32'(base_cnt));
    chk("stall_done_pulses", done_n, 1);

    // Reset mid-sweep, then a clean full sweep.
    sweep(-1, 100, -1);
    sweep(-1, -1, -1);
    chk("postrst_results", rec_n, 256);
    chk("postrst_order", order_err, 0);
    chk("postrst_flags_model", flag_err, 0);
    chk("postrst_cand_count", 32'(cand_count), 32'(base_cnt));
    chk("postrst_done_pulses", done_n, 1);

    // Stray start during SCAN must not restart or disturb the sweep.
    sweep(-1, -1, 50);
    chk("restart_results", rec_n, 256);
    chk("restart_order", order_err, 0);
    chk("restart_cand_count", 32'(cand_count), 32'(base_cnt));
    chk("restart_done_pulses", done_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
